// File: rtl/aoc5_range_merger.sv
// Range merger: loads inclusive ID ranges two per cycle into even/odd banks,
// sorts them by lower bound with odd-even transposition, then merges overlaps in place.
// Latency after stream_done_in: DEPTH sort cycles + loaded_count+1 merge cycles.
// Loads are ignored outside LOAD. Define AOC5_FRESH_TOTAL_EN to add the fresh_total output.
module aoc5_range_merger #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 9
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         data_valid_in,
  input  logic                         stream_done_in,
  input  logic [BANK_ADDR_WIDTH-1:0]   tb_addr_in,
  input  logic [2*DATA_WIDTH-1:0]      tb_even_data_in,
  input  logic [2*DATA_WIDTH-1:0]      tb_odd_data_in,
  output logic                         sort_done,
  output logic                         busy,
  output logic [BANK_ADDR_WIDTH:0]     merged_count
`ifdef AOC5_FRESH_TOTAL_EN
  ,
  output logic [DATA_WIDTH-1:0]        fresh_total
`endif
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = BANK_ADDR_WIDTH;
  localparam int EW    = 2 * DW;
  localparam int DEPTH = 1 << AW;
  localparam int ROWS  = DEPTH / 2;

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_MERGE, S_DONE} state_t;

  // Entry layout: lower bound in the upper half, upper bound in the lower half.
  function automatic logic [DW-1:0] first_of(input logic [EW-1:0] e);
    return e[EW-1:DW];
  endfunction

  function automatic logic [DW-1:0] second_of(input logic [EW-1:0] e);
    return e[DW-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [EW-1:0]     bank_even_q [ROWS];
  logic [EW-1:0]     bank_even_d [ROWS];
  logic [EW-1:0]     bank_odd_q  [ROWS];
  logic [EW-1:0]     bank_odd_d  [ROWS];
  logic [AW:0]       loaded_count_q, loaded_count_d;
  logic [AW:0]       step_q, step_d;        // sort round or merge read index
  logic [AW:0]       wr_idx_q, wr_idx_d;    // merge write index
  logic [DW-1:0]     cur_first_q, cur_first_d;
  logic [DW-1:0]     cur_second_q, cur_second_d;
  logic              sort_done_q, sort_done_d;
  logic              busy_q, busy_d;
  logic [AW:0]       merged_count_q, merged_count_d;
`ifdef AOC5_FRESH_TOTAL_EN
  logic [DW-1:0]     total_q, total_d;
`endif

  logic [EW-1:0]     rd_entry;
  logic              wr_cur;
  logic [AW:0]       addr_plus2;

  // Next-state logic for control, banks and merge accumulator.
  always_comb begin
    state_d        = state_q;
    bank_even_d    = bank_even_q;
    bank_odd_d     = bank_odd_q;
    loaded_count_d = loaded_count_q;
    step_d         = step_q;
    wr_idx_d       = wr_idx_q;
    cur_first_d    = cur_first_q;
    cur_second_d   = cur_second_q;
    sort_done_d    = 1'b0;
    merged_count_d = merged_count_q;
`ifdef AOC5_FRESH_TOTAL_EN
    total_d        = total_q;
`endif
    wr_cur         = 1'b0;
    addr_plus2     = {1'b0, tb_addr_in} + (AW+1)'(2);
    rd_entry       = step_q[0] ? bank_odd_q[step_q[AW-1:1]] : bank_even_q[step_q[AW-1:1]];

    case (state_q)
      S_LOAD: begin
        // The top pair slot would straddle the end of the store, so it is dropped.
        if (data_valid_in && (tb_addr_in != '1)) begin
          bank_even_d[tb_addr_in[AW-1:1]] = tb_even_data_in;
          bank_odd_d[tb_addr_in[AW-1:1]]  = tb_odd_data_in;
          if (addr_plus2 > loaded_count_q) loaded_count_d = addr_plus2;
        end
        if (stream_done_in) begin
          step_d = '0;
          if (loaded_count_d == '0) begin
            state_d        = S_DONE;
            sort_done_d    = 1'b1;
            merged_count_d = '0;
          end else begin
            state_d = S_SORT;
          end
        end
      end

      S_SORT: begin
        // Even rounds compare (2r,2r+1) within a row; odd rounds compare (2r+1,2r+2) across rows.
        if (!step_q[0]) begin
          for (int r = 0; r < ROWS; r++) begin
            if (first_of(bank_even_q[r]) > first_of(bank_odd_q[r])) begin
              bank_even_d[r] = bank_odd_q[r];
              bank_odd_d[r]  = bank_even_q[r];
            end
          end
        end else begin
          for (int r = 0; r < ROWS - 1; r++) begin
            if (first_of(bank_odd_q[r]) > first_of(bank_even_q[r+1])) begin
              bank_odd_d[r]    = bank_even_q[r+1];
              bank_even_d[r+1] = bank_odd_q[r];
            end
          end
        end
        step_d = step_q + (AW+1)'(1);
        if (step_q == (AW+1)'(DEPTH - 1)) begin
          state_d = S_MERGE;
          step_d  = '0;
        end
      end

      S_MERGE: begin
        step_d = step_q + (AW+1)'(1);
        if (step_q == '0) begin
          cur_first_d  = first_of(bank_even_q[0]);
          cur_second_d = second_of(bank_even_q[0]);
          wr_idx_d     = '0;
        end else if (step_q < loaded_count_q) begin
          // Overlap only: a range starting at cur.second+1 opens a new output range.
          if (first_of(rd_entry) <= cur_second_q) begin
            if (second_of(rd_entry) > cur_second_q) cur_second_d = second_of(rd_entry);
          end else begin
            wr_cur       = 1'b1;
            wr_idx_d     = wr_idx_q + (AW+1)'(1);
            cur_first_d  = first_of(rd_entry);
            cur_second_d = second_of(rd_entry);
          end
        end else begin
          wr_cur         = 1'b1;
          merged_count_d = wr_idx_q + (AW+1)'(1);
          state_d        = S_DONE;
          sort_done_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_DONE;
      end
    endcase

    // Write index never passes the read index, so writing back never clobbers unread data.
    if (wr_cur) begin
      if (wr_idx_q[0]) bank_odd_d[wr_idx_q[AW-1:1]]  = {cur_first_q, cur_second_q};
      else             bank_even_d[wr_idx_q[AW-1:1]] = {cur_first_q, cur_second_q};
`ifdef AOC5_FRESH_TOTAL_EN
      total_d = total_q + (cur_second_q - cur_first_q) + DW'(1);
`endif
    end

    busy_d = (state_d == S_SORT) || (state_d == S_MERGE);
  end

  // State registers with synchronous reset; empty entries are all-ones so they sort last.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        bank_even_q[r] <= '1;
        bank_odd_q[r]  <= '1;
      end
      state_q        <= S_LOAD;
      loaded_count_q <= '0;
      step_q         <= '0;
      wr_idx_q       <= '0;
      cur_first_q    <= '0;
      cur_second_q   <= '0;
      sort_done_q    <= 1'b0;
      busy_q         <= 1'b0;
      merged_count_q <= '0;
`ifdef AOC5_FRESH_TOTAL_EN
      total_q        <= '0;
`endif
    end else begin
      bank_even_q    <= bank_even_d;
      bank_odd_q     <= bank_odd_d;
      state_q        <= state_d;
      loaded_count_q <= loaded_count_d;
      step_q         <= step_d;
      wr_idx_q       <= wr_idx_d;
      cur_first_q    <= cur_first_d;
      cur_second_q   <= cur_second_d;
      sort_done_q    <= sort_done_d;
      busy_q         <= busy_d;
      merged_count_q <= merged_count_d;
`ifdef AOC5_FRESH_TOTAL_EN
      total_q        <= total_d;
`endif
    end
  end

  assign sort_done    = sort_done_q;
  assign busy         = busy_q;
  assign merged_count = merged_count_q;
`ifdef AOC5_FRESH_TOTAL_EN
  assign fresh_total  = total_q;
`endif

endmodule

// File: tb/tb_aoc5_range_merger.sv
// Testbench for aoc5_range_merger: scenario tasks with a reference model that
// pushes expected merged ranges into a queue, popped and compared after sort_done.
module tb_aoc5_range_merger;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int BOUND = 4 * DEPTH + 50;

  logic              clock = 1'b0;
  logic              reset;
  logic              dv;
  logic              sd;
  logic [AW-1:0]     addr;
  logic [2*DW-1:0]   even_dat;
  logic [2*DW-1:0]   odd_dat;
  logic              sort_done;
  logic              busy;
  logic [AW:0]       merged_count;
`ifdef AOC5_FRESH_TOTAL_EN
  logic [DW-1:0]     fresh_total;
`endif

  int errors = 0;
  int checks = 0;

  logic [2*DW-1:0]   model_mem [DEPTH];
  int                model_lc;
  logic [2*DW-1:0]   exp_q [$];
  int                exp_count;
  logic [DW-1:0]     exp_total;

  aoc5_range_merger #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .data_valid_in   (dv),
    .stream_done_in  (sd),
    .tb_addr_in      (addr),
    .tb_even_data_in (even_dat),
    .tb_odd_data_in  (odd_dat),
    .sort_done       (sort_done),
    .busy            (busy),
    .merged_count    (merged_count)
`ifdef AOC5_FRESH_TOTAL_EN
    ,
    .fresh_total     (fresh_total)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [2*DW-1:0] mk(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {a, b};
  endfunction

  function automatic logic [2*DW-1:0] dut_entry(input int e);
    if (e % 2 == 1) return dut.bank_odd_q[e/2];
    return dut.bank_even_q[e/2];
  endfunction

  // One-cycle reset; all driving happens just after a falling edge.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; dv = 1'b0; sd = 1'b0; addr = '0; even_dat = '0; odd_dat = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '1;
    model_lc = 0;
    exp_q.delete();
  endtask

  task automatic load_pair(input int a, input logic [2*DW-1:0] e, input logic [2*DW-1:0] o);
    dv = 1'b1; addr = AW'(a); even_dat = e; odd_dat = o;
    @(negedge clock);
    dv = 1'b0;
    if (a < DEPTH - 1) begin
      model_mem[a] = e;
      model_mem[a+1] = o;
      if (a + 2 > model_lc) model_lc = a + 2;
    end
  endtask

  // Reference: stable sort of the whole store, then overlap-only merge over loaded entries.
  task automatic model_expect();
    logic [2*DW-1:0] s [DEPTH];
    logic [2*DW-1:0] t;
    logic [DW-1:0] cf, cs;
    int j;
    exp_q.delete();
    exp_count = 0;
    exp_total = '0;
    for (int i = 0; i < DEPTH; i++) s[i] = model_mem[i];
    for (int i = 1; i < DEPTH; i++) begin
      t = s[i];
      j = i - 1;
      while (j >= 0 && s[j][2*DW-1:DW] > t[2*DW-1:DW]) begin
        s[j+1] = s[j];
        j--;
      end
      s[j+1] = t;
    end
    if (model_lc > 0) begin
      cf = s[0][2*DW-1:DW];
      cs = s[0][DW-1:0];
      for (int k = 1; k < model_lc; k++) begin
        if (s[k][2*DW-1:DW] <= cs) begin
          if (s[k][DW-1:0] > cs) cs = s[k][DW-1:0];
        end else begin
          exp_q.push_back({cf, cs});
          exp_total = exp_total + (cs - cf) + 1;
          cf = s[k][2*DW-1:DW];
          cs = s[k][DW-1:0];
        end
      end
      exp_q.push_back({cf, cs});
      exp_total = exp_total + (cs - cf) + 1;
    end
    exp_count = exp_q.size();
  endtask

  // Bounded wait for sort_done; returns cycles waited, or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (sort_done !== 1'b1 && cyc < BOUND) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (sort_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: sort_done not seen within %0d cycles", BOUND);
      cyc = -1;
    end
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (sort_done !== 1'b0) begin errors++; $display("FAIL reset_sort_done got %b want 0", sort_done); end
    checks++; if (merged_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", merged_count); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut_entry(i) !== '1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_mem got %0d non-MAX entries want 0", bad); end
  endtask

  task automatic test_basic_merge();
    int cyc;
    logic [2*DW-1:0] first_exp;
    do_reset();
    load_pair(0, mk(3, 5), mk(10, 14));
    load_pair(2, mk(16, 20), mk(12, 18));
    model_expect();
    first_exp = exp_q[0];
    sd = 1'b1;
    @(negedge clock);
    sd = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", busy); end
    wait_done(cyc);
    // sort_done appears DEPTH sort rounds + loaded_count+1 merge cycles after the SORT entry edge
    checks++; if (cyc != DEPTH + model_lc + 1) begin errors++; $display("FAIL t1_latency got %0d want %0d", cyc, DEPTH + model_lc + 1); end
    checks++; if (merged_count !== (AW+1)'(exp_count)) begin errors++; $display("FAIL t1_count got %0d want %0d", merged_count, exp_count); end
`ifdef AOC5_FRESH_TOTAL_EN
    checks++; if (fresh_total !== exp_total) begin errors++; $display("FAIL t1_total got %0d want %0d", fresh_total, exp_total); end
`endif
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [2*DW-1:0] w;
      w = exp_q.pop_front();
      checks++; if (dut_entry(i) !== w) begin errors++; $display("FAIL t1_entry%0d got %h want %h", i, dut_entry(i), w); end
    end
    // Loads in DONE are ignored and sort_done lasts one cycle.
    load_pair(0, mk(7, 7), mk(0, 0));
    checks++; if (sort_done !== 1'b0) begin errors++; $display("FAIL t1_pulse got %b want 0", sort_done); end
    checks++; if (dut_entry(0) !== first_exp) begin errors++; $display("FAIL t1_done_hold got %h want %h", dut_entry(0), first_exp); end
    checks++; if (merged_count !== (AW+1)'(exp_count)) begin errors++; $display("FAIL t1_count_hold got %0d want %0d", merged_count, exp_count); end
  endtask

  task automatic test_adjacent();
    int cyc;
    do_reset();
    load_pair(0, mk(1, 2), mk(3, 4));
    model_expect();
    sd = 1'b1; @(negedge clock); sd = 1'b0;
    wait_done(cyc);
    checks++; if (merged_count !== (AW+1)'(exp_count)) begin errors++; $display("FAIL t2_count got %0d want %0d", merged_count, exp_count); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [2*DW-1:0] w;
      w = exp_q.pop_front();
      checks++; if (dut_entry(i) !== w) begin errors++; $display("FAIL t2_entry%0d got %h want %h", i, dut_entry(i), w); end
    end
  endtask

  task automatic test_contained();
    int cyc;
    do_reset();
    load_pair(0, mk(5, 9), mk(1, 3));
    load_pair(2, mk(2, 6), mk(8, 8));
    model_expect();
    sd = 1'b1; @(negedge clock); sd = 1'b0;
    wait_done(cyc);
    checks++; if (merged_count !== (AW+1)'(exp_count)) begin errors++; $display("FAIL t3_count got %0d want %0d", merged_count, exp_count); end
`ifdef AOC5_FRESH_TOTAL_EN
    checks++; if (fresh_total !== exp_total) begin errors++; $display("FAIL t3_total got %0d want %0d", fresh_total, exp_total); end
`endif
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [2*DW-1:0] w;
      w = exp_q.pop_front();
      checks++; if (dut_entry(i) !== w) begin errors++; $display("FAIL t3_entry%0d got %h want %h", i, dut_entry(i), w); end
    end
  endtask

  task automatic test_empty();
    do_reset();
    sd = 1'b1; @(negedge clock); sd = 1'b0;
    checks++; if (sort_done !== 1'b1) begin errors++; $display("FAIL t4_sort_done got %b want 1", sort_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy got %b want 0", busy); end
    checks++; if (merged_count !== '0) begin errors++; $display("FAIL t4_count got %0d want 0", merged_count); end
    checks++; if (dut_entry(0) !== '1) begin errors++; $display("FAIL t4_entry0 got %h want all-ones", dut_entry(0)); end
    @(negedge clock);
    checks++; if (sort_done !== 1'b0) begin errors++; $display("FAIL t4_pulse got %b want 0", sort_done); end
  endtask

  task automatic test_ignore_during_sort();
    int cyc;
    do_reset();
    load_pair(0, mk(3, 5), mk(10, 14));
    load_pair(2, mk(16, 20), mk(12, 18));
    model_expect();
    sd = 1'b1; @(negedge clock);
    // Loads and a repeated stream_done while sorting must leave no trace.
    dv = 1'b1; addr = '0; even_dat = mk(7, 7); odd_dat = mk(0, 0);
    repeat (3) @(negedge clock);
    dv = 1'b0; sd = 1'b0;
    wait_done(cyc);
    checks++; if (merged_count !== (AW+1)'(exp_count)) begin errors++; $display("FAIL t5_count got %0d want %0d", merged_count, exp_count); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [2*DW-1:0] w;
      w = exp_q.pop_front();
      checks++; if (dut_entry(i) !== w) begin errors++; $display("FAIL t5_entry%0d got %h want %h", i, dut_entry(i), w); end
    end
  endtask

  task automatic test_reset_mid_merge();
    int cyc;
    int bad;
    do_reset();
    load_pair(0, mk(3, 5), mk(10, 14));
    load_pair(2, mk(16, 20), mk(12, 18));
    sd = 1'b1; @(negedge clock); sd = 1'b0;
    repeat (DEPTH + 2) @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_busy_merge got %b want 1", busy); end
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy got %b want 0", busy); end
    checks++; if (merged_count !== '0) begin errors++; $display("FAIL t6_count0 got %0d want 0", merged_count); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut_entry(i) !== '1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL t6_mem got %0d non-MAX entries want 0", bad); end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '1;
    model_lc = 0;
    load_pair(0, mk(3, 5), mk(10, 14));
    load_pair(2, mk(16, 20), mk(12, 18));
    model_expect();
    sd = 1'b1; @(negedge clock); sd = 1'b0;
    wait_done(cyc);
    checks++; if (merged_count !== (AW+1)'(exp_count)) begin errors++; $display("FAIL t6_count got %0d want %0d", merged_count, exp_count); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [2*DW-1:0] w;
      w = exp_q.pop_front();
      checks++; if (dut_entry(i) !== w) begin errors++; $display("FAIL t6_entry%0d got %h want %h", i, dut_entry(i), w); end
    end
  endtask

  task automatic test_addr_drop();
    int cyc;
    do_reset();
    load_pair(0, mk(20, 30), mk(40, 50));
    load_pair(DEPTH - 1, mk(1, 1), mk(2, 2));
    model_expect();
    sd = 1'b1; @(negedge clock); sd = 1'b0;
    wait_done(cyc);
    checks++; if (cyc != DEPTH + 3) begin errors++; $display("FAIL drop_latency got %0d want %0d", cyc, DEPTH + 3); end
    checks++; if (merged_count !== (AW+1)'(exp_count)) begin errors++; $display("FAIL drop_count got %0d want %0d", merged_count, exp_count); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [2*DW-1:0] w;
      w = exp_q.pop_front();
      checks++; if (dut_entry(i) !== w) begin errors++; $display("FAIL drop_entry%0d got %h want %h", i, dut_entry(i), w); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [DW-1:0] a0, a1;
    do_reset();
    for (int r = 0; r < DEPTH / 2; r++) begin
      a0 = DW'($urandom_range(0, 120));
      a1 = DW'($urandom_range(0, 120));
      load_pair(2 * r, mk(a0, a0 + DW'($urandom_range(0, 12))), mk(a1, a1 + DW'($urandom_range(0, 12))));
    end
    model_expect();
    sd = 1'b1; @(negedge clock); sd = 1'b0;
    wait_done(cyc);
    checks++; if (merged_count !== (AW+1)'(exp_count)) begin errors++; $display("FAIL b2b_count got %0d want %0d", merged_count, exp_count); end
`ifdef AOC5_FRESH_TOTAL_EN
    checks++; if (fresh_total !== exp_total) begin errors++; $display("FAIL b2b_total got %0d want %0d", fresh_total, exp_total); end
`endif
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [2*DW-1:0] w;
      w = exp_q.pop_front();
      checks++; if (dut_entry(i) !== w) begin errors++; $display("FAIL b2b_entry%0d got %h want %h", i, dut_entry(i), w); end
    end
  endtask

  initial begin
    reset = 1'b1; dv = 1'b0; sd = 1'b0; addr = '0; even_dat = '0; odd_dat = '0;
    test_reset();
    test_basic_merge();
    test_adjacent();
    test_contained();
    test_empty();
    test_ignore_during_sort();
    test_reset_mid_merge();
    test_addr_drop();
    test_back_to_back();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
